// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer block: FSM state encoding.
package down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : down_timer_pkg

// File: rtl/down_timer_subtractor.sv
// Ripple-borrow subtractor (diff = a - b - bin) built from full-subtractor cells.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule : full_subtractor

module ripple_borrow_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    logic [WIDTH:0] brw;

    assign brw[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor u_fs (
            .a   (a[i]),
            .b   (b[i]),
            .bin (brw[i]),
            .diff(diff[i]),
            .bout(brw[i+1])
        );
    end

    assign bout = brw[WIDTH];
endmodule : ripple_borrow_subtractor

// File: rtl/down_timer.sv
// Loadable down-counting timer: decrements every PRESCALE clocks while running,
// stops at zero with a one-cycle done pulse.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] leds,
    output logic             busy,
    output logic             done
);
    localparam int unsigned PW = $clog2(PRESCALE) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] cnt_dec;
    logic             dec_borrow;

    ripple_borrow_subtractor #(.WIDTH(WIDTH)) u_dec (
        .a   (cnt_q),
        .b   (WIDTH'(1)),
        .bin (1'b0),
        .diff(cnt_dec),
        .bout(dec_borrow)
    );

    // Next-state logic; priority is load > pause > start (rst handled in the register)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        if (load) begin
            cnt_d   = load_val;
            presc_d = '0;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && (cnt_q != '0)) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (presc_q == PW'(PRESCALE - 1)) begin
                        presc_d = '0;
                        // A borrow would mean an underflow; clamp so the count never wraps
                        cnt_d   = dec_borrow ? '0 : cnt_dec;
                        if ((cnt_q == WIDTH'(1)) || dec_borrow) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSED: begin
                    if (!pause && start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign leds = cnt_q;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized run
// against a behavioural model, for PRESCALE=4 and PRESCALE=1 instances.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       rst, load, start, pause;
    logic [7:0] load_val;
    logic [7:0] leds4, leds1;
    logic       busy4, done4, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: index 0 -> PRESCALE 4, index 1 -> PRESCALE 1
    int m_pre [2] = '{4, 1};
    int m_cnt [2];
    int m_el  [2];
    int m_mode[2];   // 0 idle, 1 running, 2 paused, 3 finished
    int m_done[2];

    always #5 clk = ~clk;

    down_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause),
        .leds(leds4), .busy(busy4), .done(done4)
    );

    down_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause),
        .leds(leds1), .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = 8'd0;
        tick(); tick();
        n_checks++;
        if ({leds4, busy4, done4} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_p4: got leds=%0d busy=%b done=%b, want 0 0 0", leds4, busy4, done4);
        end
        n_checks++;
        if ({leds1, busy1, done1} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_p1: got leds=%0d busy=%b done=%b, want 0 0 0", leds1, busy1, done1);
        end
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({leds4, busy4, done4} !== 10'b0) begin
            n_fail++;
            $display("FAIL start_at_zero: got leds=%0d busy=%b done=%b, want 0 0 0", leds4, busy4, done4);
        end
        tick();
        n_checks++;
        if (busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_at_zero_idle: got busy=%b, want 0", busy4);
        end
    endtask

    task automatic test_countdown();
        logic [7:0] el;
        logic       eb, ed;
        idle_inputs();
        load = 1'b1; load_val = 8'd3; tick();
        load = 1'b0; start = 1'b1; tick();      // edge k
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            el = (i >= 12) ? 8'd0 : 8'(3 - i / 4);
            eb = (i < 12);
            ed = (i == 12);
            n_checks++;
            if ({leds4, busy4, done4} !== {el, eb, ed}) begin
                n_fail++;
                $display("FAIL countdown k+%0d: got leds=%0d busy=%b done=%b, want %0d %b %b",
                         i, leds4, busy4, done4, el, eb, ed);
            end
        end
    endtask

    task automatic test_pause();
        idle_inputs();
        load = 1'b1; load_val = 8'd5; tick();
        load = 1'b0; start = 1'b1; tick();      // edge k
        start = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        pause = 1'b1; tick();                    // edge k+6
        pause = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin pause = 1'b1; start = 1'b1; end
            tick();
            pause = 1'b0; start = 1'b0;
            n_checks++;
            if ({leds4, busy4, done4} !== {8'd4, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL pause_hold %0d: got leds=%0d busy=%b done=%b, want 4 1 0",
                         i, leds4, busy4, done4);
            end
        end
        start = 1'b1; tick();                    // edge m
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if ({leds4, busy4} !== {((i == 3) ? 8'd3 : 8'd4), 1'b1}) begin
                n_fail++;
                $display("FAIL resume m+%0d: got leds=%0d busy=%b, want %0d 1",
                         i, leds4, busy4, (i == 3) ? 3 : 4);
            end
        end
    endtask

    task automatic test_load_abort();
        idle_inputs();
        load = 1'b1; load_val = 8'd9; tick();
        load = 1'b0; start = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        load = 1'b1; load_val = 8'd7; tick();
        load = 1'b0;
        n_checks++;
        if ({leds4, busy4, done4} !== {8'd7, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL load_abort: got leds=%0d busy=%b done=%b, want 7 0 0", leds4, busy4, done4);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({leds4, busy4, done4} !== {8'd7, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL load_abort_idle %0d: got leds=%0d busy=%b done=%b, want 7 0 0",
                         i, leds4, busy4, done4);
            end
        end
    endtask

    task automatic test_prescale1();
        logic [7:0] el;
        idle_inputs();
        load = 1'b1; load_val = 8'd255; tick();
        load = 1'b0; start = 1'b1; tick();      // edge k
        start = 1'b0;
        for (int i = 1; i <= 275; i++) begin
            tick();
            el = (i >= 255) ? 8'd0 : 8'(255 - i);
            n_checks++;
            if ({leds1, busy1, done1} !== {el, (i < 255), (i == 255)}) begin
                n_fail++;
                $display("FAIL prescale1 k+%0d: got leds=%0d busy=%b done=%b, want %0d %b %b",
                         i, leds1, busy1, done1, el, (i < 255), (i == 255));
            end
        end
    endtask

    task automatic test_rst_mid_run();
        idle_inputs();
        load = 1'b1; load_val = 8'd5; tick();
        load = 1'b0; start = 1'b1; tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; start = 1'b1; pause = 1'b1; tick();
        n_checks++;
        if ({leds4, busy4, done4, leds1, busy1, done1} !== 20'b0) begin
            n_fail++;
            $display("FAIL rst_mid_run: got p4 %0d %b %b p1 %0d %b %b, want all 0",
                     leds4, busy4, done4, leds1, busy1, done1);
        end
        idle_inputs(); start = 1'b1; tick();
        start = 1'b0;
        n_checks++;
        if ({leds4, busy4, done4} !== 10'b0) begin
            n_fail++;
            $display("FAIL rst_then_idle: got leds=%0d busy=%b done=%b, want 0 0 0", leds4, busy4, done4);
        end
    endtask

    task automatic model_step(int j);
        if (rst) begin
            m_cnt[j] = 0; m_el[j] = 0; m_mode[j] = 0; m_done[j] = 0;
        end else if (load) begin
            m_cnt[j] = int'(load_val); m_el[j] = 0; m_mode[j] = 0; m_done[j] = 0;
        end else begin
            m_done[j] = 0;
            case (m_mode[j])
                0: if (start && m_cnt[j] > 0) begin m_mode[j] = 1; m_el[j] = 0; end
                1: if (pause) m_mode[j] = 2;
                   else begin
                       m_el[j]++;
                       if (m_el[j] == m_pre[j]) begin
                           m_el[j] = 0;
                           m_cnt[j]--;
                           if (m_cnt[j] == 0) begin m_mode[j] = 3; m_done[j] = 1; end
                       end
                   end
                2: if (!pause && start) m_mode[j] = 1;
                default: ;
            endcase
        end
    endtask

    task automatic test_random();
        logic [7:0] gl [2];
        logic       gb [2], gd [2];
        idle_inputs(); rst = 1'b1;
        model_step(0); model_step(1); tick();
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 59) == 0);
            load_val = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            start = ($urandom_range(0, 3) == 0);
            pause = ($urandom_range(0, 7) == 0) && (m_mode[0] != 0) && (m_mode[1] != 0);
            model_step(0); model_step(1);
            tick();
            gl[0] = leds4; gb[0] = busy4; gd[0] = done4;
            gl[1] = leds1; gb[1] = busy1; gd[1] = done1;
            for (int j = 0; j < 2; j++) begin
                n_checks++;
                if ({gl[j], gb[j], gd[j]} !==
                    {8'(m_cnt[j]), (m_mode[j] == 1 || m_mode[j] == 2), (m_done[j] != 0)}) begin
                    n_fail++;
                    $display("FAIL random p%0d cyc %0d: got leds=%0d busy=%b done=%b, want %0d %b %b",
                             m_pre[j], c, gl[j], gb[j], gd[j], m_cnt[j],
                             (m_mode[j] == 1 || m_mode[j] == 2), (m_done[j] != 0));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = 8'd0;
        test_reset();
        test_countdown();
        test_pause();
        test_load_abort();
        test_prescale1();
        test_rst_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_down_timer
